// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory boot loader.
// Memory geometry and FSM state encodings.
package imem_loader_pkg;

    localparam int IMEM_ADDR_W = 11;
    localparam int IMEM_WORDS  = 2048;

    localparam logic [2:0] S_HDR_HI  = 3'd0;
    localparam logic [2:0] S_HDR_LO  = 3'd1;
    localparam logic [2:0] S_PAYLOAD = 3'd2;
    localparam logic [2:0] S_CHECK   = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;
    localparam logic [2:0] S_ERR     = 3'd5;

endpackage

// File: rtl/loader_word_asm.sv
// Big-endian word assembler with running XOR checksum.
// word_ready flags the shift that completes a 32-bit word.
module loader_word_asm
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_next,
    output logic [7:0]  csum,
    output logic        word_ready
);

    logic [31:0] word_q, word_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  csum_q, csum_d;

    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        csum_d = csum_q;
        if (clear) begin
            word_d = '0;
            idx_d  = '0;
            csum_d = '0;
        end else if (shift_en) begin
            word_d = {word_q[23:0], byte_in};
            idx_d  = idx_q + 2'd1;
            csum_d = csum_q ^ byte_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
            idx_q  <= '0;
            csum_q <= '0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
            csum_q <= csum_d;
        end
    end

    assign word_next  = {word_q[23:0], byte_in};
    assign csum       = csum_q;
    assign word_ready = shift_en && !clear && (idx_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: framed byte stream -> instruction memory writes.
// Keeps the CPU in reset until a checksummed frame is in memory.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = IMEM_ADDR_W,
    parameter int MAX_WORDS = IMEM_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              start,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_rst_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [ADDR_W:0] WL_ONE = 1;

    logic [2:0]        state_q, state_d;
    logic [15:0]       count_q, count_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [ADDR_W:0]   wl_q, wl_d;

    logic        xfer;
    logic        clear;
    logic        shift_en;
    logic [15:0] hdr_n;
    logic [31:0] word_next;
    logic [7:0]  csum;
    logic        word_ready;

    assign in_ready = (state_q != S_DONE) && (state_q != S_ERR);
    assign xfer     = in_valid && in_ready;
    assign hdr_n    = {count_q[15:8], in_data};

    loader_word_asm u_asm (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .shift_en  (shift_en),
        .byte_in   (in_data),
        .word_next (word_next),
        .csum      (csum),
        .word_ready(word_ready)
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        wl_d        = wl_q;
        clear       = 1'b0;
        shift_en    = 1'b0;
        case (state_q)
            S_HDR_HI: begin
                if (xfer) begin
                    count_d[15:8] = in_data;
                    state_d       = S_HDR_LO;
                end
            end
            S_HDR_LO: begin
                if (xfer) begin
                    count_d = hdr_n;
                    if (hdr_n > 16'(MAX_WORDS))
                        state_d = S_ERR;
                    else if (hdr_n == 16'd0)
                        state_d = S_CHECK;
                    else
                        state_d = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                shift_en = xfer;
                // word index is the number of words already written
                if (word_ready) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = wl_q[ADDR_W-1:0];
                    mem_wdata_d = word_next;
                    wl_d        = wl_q + WL_ONE;
                    if (count_q == 16'(wl_q + WL_ONE))
                        state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (xfer)
                    state_d = (in_data == csum) ? S_DONE : S_ERR;
            end
            S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_HDR_HI;
                    count_d = '0;
                    wl_d    = '0;
                    clear   = 1'b1;
                end
            end
            default: state_d = S_HDR_HI;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_HDR_HI;
            count_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wl_q        <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            wl_q        <= wl_d;
        end
    end

    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign words_loaded = wl_q;
    assign done         = (state_q == S_DONE);
    assign error        = (state_q == S_ERR);
    assign cpu_rst_hold = (state_q != S_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frames, checksums, limits,
// reset mid-frame and re-arm via start.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        start = 1'b0;
    logic        in_ready;
    logic        mem_we;
    logic [10:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_rst_hold;
    logic        done;
    logic        error;
    logic [11:0] words_loaded;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc = 0;
    int dbl = 0;
    int a0 = 0;
    int a1 = 0;
    logic prev_we = 1'b0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    int wc[$];

    imem_loader dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .start       (start),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .cpu_rst_hold(cpu_rst_hold),
        .done        (done),
        .error       (error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (mem_we) begin
            wa.push_back(32'(mem_addr));
            wd.push_back(mem_wdata);
            wc.push_back(cyc);
        end
        if (mem_we && prev_we) dbl++;
        prev_we = mem_we;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_data  = 8'hFF;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        acc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        wc.delete();
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);
        clear_log();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // payload XOR of DE AD BE EF 01 23 45 67 is 0x22
    logic [7:0] f_good[11] = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE,
        8'hEF, 8'h01, 8'h23, 8'h45, 8'h67, 8'h22};
    int gaps[11] = '{0, 2, 1, 0, 3, 0, 2, 1, 0, 2, 1};

    initial begin
        idle(2);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_hold", 32'(cpu_rst_hold), 1);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_wl", 32'(words_loaded), 0);
        rst = 1'b0;
        idle(1);
        clear_log();

        for (int i = 0; i < 11; i++) begin
            send(f_good[i]);
            if (i == 5) a0 = acc;
            if (i == 9) a1 = acc;
        end
        idle(2);
        chk("t1_nwr", wa.size(), 2);
        chk("t1_a0", wa[0], 0);
        chk("t1_d0", wd[0], 32'hDEADBEEF);
        chk("t1_c0", wc[0], a0);
        chk("t1_a1", wa[1], 1);
        chk("t1_d1", wd[1], 32'h01234567);
        chk("t1_c1", wc[1], a1);
        chk("t1_done", 32'(done), 1);
        chk("t1_hold", 32'(cpu_rst_hold), 0);
        chk("t1_wl", 32'(words_loaded), 2);
        chk("t1_ready", 32'(in_ready), 0);

        do_reset();
        for (int i = 0; i < 10; i++) send(f_good[i]);
        send(8'h23);
        idle(2);
        chk("t2_nwr", wa.size(), 2);
        chk("t2_d1", wd[1], 32'h01234567);
        chk("t2_error", 32'(error), 1);
        chk("t2_done", 32'(done), 0);
        chk("t2_hold", 32'(cpu_rst_hold), 1);
        chk("t2_ready", 32'(in_ready), 0);

        do_reset();
        send(8'h08);
        send(8'h01);
        chk("t3_error", 32'(error), 1);
        chk("t3_ready", 32'(in_ready), 0);
        idle(2);
        chk("t3_nwr", wa.size(), 0);

        pulse_start();
        chk("t4_err_clr", 32'(error), 0);
        chk("t4_ready", 32'(in_ready), 1);
        send(8'h00);
        send(8'h00);
        send(8'h00);
        chk("t4_done", 32'(done), 1);
        chk("t4_nwr", wa.size(), 0);
        do_reset();
        send(8'h00);
        send(8'h00);
        send(8'h01);
        chk("t4_bad_err", 32'(error), 1);

        do_reset();
        for (int i = 0; i < 11; i++) begin
            idle(gaps[i]);
            send(f_good[i]);
            if (i == 5) a0 = acc;
            if (i == 9) a1 = acc;
        end
        idle(2);
        chk("t5_nwr", wa.size(), 2);
        chk("t5_d0", wd[0], 32'hDEADBEEF);
        chk("t5_c0", wc[0], a0);
        chk("t5_a1", wa[1], 1);
        chk("t5_d1", wd[1], 32'h01234567);
        chk("t5_c1", wc[1], a1);
        chk("t5_done", 32'(done), 1);

        do_reset();
        for (int i = 0; i < 8; i++) send(f_good[i]);
        chk("t6_pre_nwr", wa.size(), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_ready", 32'(in_ready), 1);
        chk("t6_we", 32'(mem_we), 0);
        chk("t6_addr", 32'(mem_addr), 0);
        chk("t6_wdata", mem_wdata, 0);
        chk("t6_hold", 32'(cpu_rst_hold), 1);
        chk("t6_wl", 32'(words_loaded), 0);
        idle(2);
        rst = 1'b0;
        idle(3);
        chk("t6_post_nwr", wa.size(), 1);

        clear_log();
        send(8'h00);
        send(8'h01);
        send(8'h11);
        send(8'h22);
        send(8'h33);
        send(8'h44);
        send(8'h44);
        idle(1);
        chk("t7_nwr", wa.size(), 1);
        chk("t7_a0", wa[0], 0);
        chk("t7_d0", wd[0], 32'h11223344);
        chk("t7_done", 32'(done), 1);

        pulse_start();
        chk("t8_hold", 32'(cpu_rst_hold), 1);
        chk("t8_ready", 32'(in_ready), 1);
        chk("t8_done", 32'(done), 0);
        chk("t8_wl", 32'(words_loaded), 0);
        send(8'h00);
        send(8'h00);
        send(8'h00);
        chk("t8_redone", 32'(done), 1);

        do_reset();
        send(8'h08);
        send(8'h00);
        for (int k = 0; k < 8192; k++) send(8'(k));
        send(8'h00);
        idle(1);
        chk("t9_nwr", wa.size(), 2048);
        chk("t9_alast", wa[2047], 2047);
        chk("t9_dlast", wd[2047], 32'hFCFDFEFF);
        chk("t9_done", 32'(done), 1);
        chk("t9_wl", 32'(words_loaded), 2048);

        chk("no_double_we", dbl, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
